tail_light_seq: RTL and testbench
=================================

TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 Parameter LAMPS, default 3: lamps per side; legal range 1..8.
REQ-002 Parameter DIV_BITS, default 24: prescaler width; step period is 2^DIV_BITS clk cycles; legal range 1..32.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 l  input  1  left turn request, level, synchronous to clk.
REQ-006 r  input  1  right turn request, level, synchronous to clk.
REQ-007 haz  input  1  hazard request, level, synchronous to clk.
REQ-008 lamp_l  output  LAMPS  left lamps, registered; bit 0 innermost.
REQ-009 lamp_r  output  LAMPS  right lamps, registered; bit 0 innermost.
REQ-010 tick  output  1  one-cycle step strobe, combinational from registers, for observability.

Function
REQ-011 Mode register mode_q SHALL load each clk edge from inputs: haz or (l and r) -> HAZARD; else l -> LEFT; else r -> RIGHT; else IDLE.
REQ-012 Prescaler cnt (DIV_BITS wide) SHALL hold 0 while mode_q is IDLE and increment by 1 (wrapping) otherwise.
REQ-013 tick SHALL be 1 exactly when mode_q is not IDLE and cnt is all-ones.
REQ-014 On any edge where the newly loaded mode differs from mode_q, cnt, step counter k and both lamp outputs SHALL clear to 0 on that edge.
REQ-015 LEFT/RIGHT: step counter k (range 0..LAMPS) SHALL advance on each tick, wrapping from LAMPS to 0.
REQ-016 LEFT/RIGHT: active side SHALL show thermometer pattern (1 << k) - 1 (k lowest bits set); inactive side SHALL be all 0.
REQ-017 HAZARD: on each tick both lamp vectors SHALL toggle together between all-0 and all-1; first tick after entry turns them all-1.
REQ-018 IDLE: both lamp vectors SHALL be 0 and k SHALL be 0.
REQ-019 Latency: with request asserted before edge E0 and held, first visible step (lamp = 1 on bit 0, or all-1 in HAZARD) SHALL appear after edge E0 + 2^DIV_BITS.
REQ-020 Request release SHALL blank that side on the next clk edge, independent of tick.
REQ-021 LAMPS = 1 SHALL give plain on/off flashing, period 2 ticks.
REQ-022 Pattern width arithmetic SHALL be done at LAMPS+1 bits and truncated to LAMPS, so k = LAMPS yields all-1 without overflow.

Reset
REQ-023 rst high at an edge SHALL set mode_q = IDLE, cnt = 0, k = 0, lamp_l = 0, lamp_r = 0, hazard phase = off; tick is 0 while rst held.
REQ-024 rst mid-sequence SHALL take priority over tick and mode change; after release, behaviour restarts per REQ-019.

Structure
REQ-025 Package tail_light_pkg SHALL hold the mode encoding (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3) and the 2-bit mode width constant.
REQ-026 Prescaler SHALL be a sub-module tick_gen (params DIV_BITS; ports clk, rst, en, clr, tick); clr has priority over en.
REQ-027 Top-level SHALL contain one FSM for mode/k/hazard phase and registered output decode; no derived clocks; all flops on clk only.

Verification (LAMPS=3, DIV_BITS=2 unless noted)
REQ-028 rst 2 cycles, l=r=haz=0 for 20 cycles -> lamp_l = lamp_r = 000, tick never 1.
REQ-029 l=1 held from E0 -> lamp_l 001 after E0+4, 011 after E0+8, 111 after E0+12, 000 after E0+16, then repeats; lamp_r stays 000.
REQ-030 r=1 until lamp_r=011, then l=1 and r=0 same cycle -> next edge lamp_r=000, lamp_l=000; lamp_l=001 four edges later.
REQ-031 l=1 and r=1 together -> HAZARD: both sides 111 after E0+4, 000 after E0+8, 111 after E0+12.
REQ-032 l=1 until lamp_l=011, rst pulsed 1 cycle with l still 1 -> all outputs 000 at rst edge; lamp_l=001 four edges after first post-reset edge.
REQ-033 LAMPS=1, DIV_BITS=1, r=1 -> lamp_r toggles 1/0 every 2 cycles after first step; lamp_l constant 0.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light sequencer: turn/hazard mode encoding.
package tail_light_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running step prescaler: strobes once every 2^DIV_BITS enabled cycles.
module tick_gen #(
    parameter int DIV_BITS = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + DIV_BITS'(1);
        end
    end

    assign tick = en && (&cnt);

endmodule

// File: rtl/tail_light_seq.sv
// Turn-signal / hazard sequencer: thermometer sweep on the requested side,
// whole-bar flashing in hazard mode, one step per prescaler tick.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int DIV_BITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l,
    input  logic             r,
    input  logic             haz,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             tick
);

    localparam int K_W = $clog2(LAMPS + 1);

    mode_t            mode_q, mode_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             phase_q, phase_d;
    logic [LAMPS-1:0] lamp_l_d, lamp_r_d;
    logic             mode_chg;
    logic             run;

    // Computed one bit wider so k = LAMPS gives all-ones instead of wrapping to zero.
    function automatic logic [LAMPS-1:0] therm(input logic [K_W-1:0] n);
        logic [LAMPS:0] w;
        w = ({{LAMPS{1'b0}}, 1'b1} << n) - 1'b1;
        return w[LAMPS-1:0];
    endfunction

    always_comb begin
        if (haz || (l && r)) mode_d = MODE_HAZARD;
        else if (l)          mode_d = MODE_LEFT;
        else if (r)          mode_d = MODE_RIGHT;
        else                 mode_d = MODE_IDLE;
    end

    assign mode_chg = (mode_d != mode_q);
    assign run      = (mode_q != MODE_IDLE);

    tick_gen #(
        .DIV_BITS(DIV_BITS)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .clr (mode_chg),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            k_q     <= '0;
            phase_q <= 1'b0;
            lamp_l  <= '0;
            lamp_r  <= '0;
        end else begin
            mode_q  <= mode_d;
            k_q     <= k_d;
            phase_q <= phase_d;
            lamp_l  <= lamp_l_d;
            lamp_r  <= lamp_r_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        k_d     = k_q;
        phase_d = phase_q;
        if (mode_chg) begin
            k_d     = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_LEFT, MODE_RIGHT: k_d = (k_q == K_W'(LAMPS)) ? '0 : k_q + K_W'(1);
                MODE_HAZARD:           phase_d = ~phase_q;
                default:               ;
            endcase
        end
    end

    // Lamps are decoded from next state so they register in step with k and phase.
    always_comb begin
        lamp_l_d = '0;
        lamp_r_d = '0;
        case (mode_d)
            MODE_LEFT:  lamp_l_d = therm(k_d);
            MODE_RIGHT: lamp_r_d = therm(k_d);
            MODE_HAZARD: begin
                lamp_l_d = {LAMPS{phase_d}};
                lamp_r_d = {LAMPS{phase_d}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Randomised and directed bench for tail_light_seq against a step-count reference model.
module tb_tail_light_seq;

    localparam int LAMPS    = 3;
    localparam int DIV_BITS = 2;
    localparam int PERIOD   = 1 << DIV_BITS;

    logic             clk = 1'b0;
    logic             rst, l, r, haz;
    logic [LAMPS-1:0] lamp_l, lamp_r;
    logic             tick;

    logic             rst1, l1, r1, haz1;
    logic [0:0]       lamp_l1, lamp_r1;
    logic             tick1;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_IDLE, M_LEFT, M_RIGHT, M_HAZ} m_t;
    m_t m_mode = M_IDLE;
    int m_age  = 0;

    always #5 clk = ~clk;

    tail_light_seq #(.LAMPS(LAMPS), .DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .rst(rst), .l(l), .r(r), .haz(haz),
        .lamp_l(lamp_l), .lamp_r(lamp_r), .tick(tick)
    );

    tail_light_seq #(.LAMPS(1), .DIV_BITS(1)) dut1 (
        .clk(clk), .rst(rst1), .l(l1), .r(r1), .haz(haz1),
        .lamp_l(lamp_l1), .lamp_r(lamp_r1), .tick(tick1)
    );

    // Model tracks only the active mode and edges spent in it; the step count follows by division.
    function automatic void model_update(input logic rv, lv, rrv, hv);
        m_t nm;
        if (rv) begin
            m_mode = M_IDLE;
            m_age  = 0;
        end else begin
            nm = (hv || (lv && rrv)) ? M_HAZ : lv ? M_LEFT : rrv ? M_RIGHT : M_IDLE;
            if (nm != m_mode) begin
                m_mode = nm;
                m_age  = 0;
            end else if (m_mode != M_IDLE) begin
                m_age++;
            end
        end
    endfunction

    function automatic void model_expect(output logic [LAMPS-1:0] el, er, output logic et);
        int steps;
        logic [LAMPS-1:0] pat;
        steps = m_age / PERIOD;
        pat   = LAMPS'((1 << (steps % (LAMPS + 1))) - 1);
        el = '0;
        er = '0;
        case (m_mode)
            M_LEFT:  el = pat;
            M_RIGHT: er = pat;
            M_HAZ: begin
                el = (steps % 2 == 1) ? '1 : '0;
                er = el;
            end
            default: ;
        endcase
        et = (m_mode != M_IDLE) && (m_age % PERIOD == PERIOD - 1);
    endfunction

    task automatic do_edge(input logic rv, lv, rrv, hv);
        rst = rv; l = lv; r = rrv; haz = hv;
        @(posedge clk);
        model_update(rv, lv, rrv, hv);
        #1;
    endtask

    task automatic test_reset();
        logic [LAMPS-1:0] el, er;
        logic et;
        for (int i = 0; i < 22; i++) begin
            do_edge(i < 2, 1'b0, 1'b0, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL reset_idle edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         i, lamp_l, lamp_r, tick, el, er, et);
            end
        end
    endtask

    task automatic test_left();
        logic [LAMPS-1:0] el, er, fixed;
        logic et;
        do_edge(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 24; i++) begin
            do_edge(1'b0, 1'b1, 1'b0, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL left edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         i, lamp_l, lamp_r, tick, el, er, et);
            end
            if (i > 0 && i % 4 == 0) begin
                case ((i / 4) % 4)
                    1: fixed = 3'b001;
                    2: fixed = 3'b011;
                    3: fixed = 3'b111;
                    default: fixed = 3'b000;
                endcase
                checks++;
                if (lamp_l !== fixed) begin
                    failures++;
                    $display("FAIL left_sweep E0+%0d got %b want %b", i, lamp_l, fixed);
                end
            end
        end
    endtask

    task automatic test_switch();
        logic [LAMPS-1:0] el, er;
        logic et;
        int n;
        do_edge(1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            do_edge(1'b0, 1'b0, 1'b1, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL switch_right edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         n, lamp_l, lamp_r, tick, el, er, et);
            end
            n++;
        end while (lamp_r !== 3'b011 && n < 40);
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL switch_timeout got lamp_r=%b want 011 within 40 edges", lamp_r);
        end
        for (int i = 1; i <= 6; i++) begin
            do_edge(1'b0, 1'b1, 1'b0, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL switch_left edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         i, lamp_l, lamp_r, tick, el, er, et);
            end
            if (i == 1 || i == 5) begin
                checks++;
                if (lamp_r !== 3'b000 || lamp_l !== ((i == 5) ? 3'b001 : 3'b000)) begin
                    failures++;
                    $display("FAIL switch_fixed edge=%0d got l=%b r=%b want l=%b r=000",
                             i, lamp_l, lamp_r, (i == 5) ? 3'b001 : 3'b000);
                end
            end
        end
    endtask

    task automatic test_hazard();
        logic [LAMPS-1:0] el, er;
        logic et;
        do_edge(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            do_edge(1'b0, 1'b1, 1'b1, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL hazard edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         i, lamp_l, lamp_r, tick, el, er, et);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [LAMPS-1:0] el, er;
        logic et;
        int n;
        do_edge(1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            do_edge(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end while (lamp_l !== 3'b011 && n < 40);
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL rst_mid_timeout got lamp_l=%b want 011 within 40 edges", lamp_l);
        end
        do_edge(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lamp_l !== '0 || lamp_r !== '0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_clear got l=%b r=%b tick=%b want l=000 r=000 tick=0",
                     lamp_l, lamp_r, tick);
        end
        for (int i = 0; i <= 5; i++) begin
            do_edge(1'b0, 1'b1, 1'b0, 1'b0);
            model_expect(el, er, et);
            checks++;
            if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                failures++;
                $display("FAIL rst_mid_restart edge=%0d got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                         i, lamp_l, lamp_r, tick, el, er, et);
            end
        end
    endtask

    task automatic test_random();
        logic [LAMPS-1:0] el, er;
        logic et;
        logic lv, rv, hv, sv;
        int hold;
        for (int blk = 0; blk < 60; blk++) begin
            lv   = 1'($urandom_range(0, 1));
            rv   = 1'($urandom_range(0, 1));
            hv   = ($urandom_range(0, 3) == 0);
            sv   = ($urandom_range(0, 15) == 0);
            hold = $urandom_range(1, 24);
            for (int i = 0; i < hold; i++) begin
                do_edge(sv && (i == 0), lv, rv, hv);
                model_expect(el, er, et);
                checks++;
                if (lamp_l !== el || lamp_r !== er || tick !== et) begin
                    failures++;
                    $display("FAIL random blk=%0d edge=%0d in=%b%b%b%b got l=%b r=%b tick=%b want l=%b r=%b tick=%b",
                             blk, i, sv, lv, rv, hv, lamp_l, lamp_r, tick, el, er, et);
                end
            end
        end
    endtask

    task automatic test_lamps1();
        logic exp_r, exp_t;
        int age;
        rst1 = 1'b1; l1 = 1'b0; r1 = 1'b0; haz1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (lamp_l1 !== 1'b0 || lamp_r1 !== 1'b0 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL lamps1_reset got l=%b r=%b tick=%b want 0 0 0", lamp_l1, lamp_r1, tick1);
        end
        rst1 = 1'b0; r1 = 1'b1;
        age  = -1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            age++;
            #1;
            exp_r = ((age / 2) % 2 == 1);
            exp_t = (age % 2 == 1);
            checks++;
            if (lamp_l1 !== 1'b0 || lamp_r1 !== exp_r || tick1 !== exp_t) begin
                failures++;
                $display("FAIL lamps1 edge=%0d got l=%b r=%b tick=%b want l=0 r=%b tick=%b",
                         i, lamp_l1, lamp_r1, tick1, exp_r, exp_t);
            end
        end
        r1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; l = 1'b0; r = 1'b0; haz = 1'b0;
        rst1 = 1'b1; l1 = 1'b0; r1 = 1'b0; haz1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_left();
        test_switch();
        test_hazard();
        test_rst_mid();
        test_random();
        test_lamps1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
